// File: rtl/mem_pkg.sv
// Shared MEM definitions: geometry, word/address types and burst-master FSM states.
package mem_pkg;

    localparam int AWIDTH = 5;
    localparam int DWIDTH = 8;

    typedef logic [AWIDTH-1:0] addr_t;
    typedef logic [DWIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous MEM: turns (addr, len) commands into
// per-cycle write accesses fed from a stream, or read accesses returned on a stream.
module mem_burst_master #(
    parameter int AWIDTH = mem_pkg::AWIDTH,
    parameter int DWIDTH = mem_pkg::DWIDTH,
    parameter int LENW   = AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [LENW-1:0]   req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout
);
    import mem_pkg::*;

    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
    localparam logic [LENW-1:0]   CNT_ONE  = LENW'(1);
    localparam logic [LENW-1:0]   CNT_ZERO = LENW'(0);

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr;
    logic [LENW-1:0]   r_cnt;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [DWIDTH-1:0] r_rd_data;
    logic              w_mem_en;
    logic              w_mem_we;
    logic              w_req_ready;
    logic              w_wr_ready;
    logic              w_done;
    logic              w_cnt_zero;

    assign w_cnt_zero = (r_cnt == CNT_ZERO);

    // Next-state and per-cycle MEM/handshake strobes.
    always_comb begin
        w_next      = r_state;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_req_ready = 1'b0;
        w_wr_ready  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_write ? WR : RD_ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            WR: begin
                w_wr_ready = 1'b1;
                w_mem_en   = wr_valid;
                w_mem_we   = wr_valid;
                if (wr_valid && w_cnt_zero) begin
                    w_next = DONE;
                end else begin
                    w_next = WR;
                end
            end
            RD_ISSUE: begin
                // Only issue when the single output slot will be free at capture time.
                if (!r_rd_valid || rd_ready) begin
                    w_mem_en = 1'b1;
                    w_next   = RD_CAPT;
                end else begin
                    w_next = RD_ISSUE;
                end
            end
            RD_CAPT: begin
                if (w_cnt_zero) begin
                    w_next = DONE;
                end else begin
                    w_next = RD_ISSUE;
                end
            end
            DONE: begin
                if (!r_rd_valid) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address and remaining-beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        r_cnt  <= req_len;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        r_addr <= r_addr + ADDR_ONE;
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                RD_CAPT: begin
                    r_addr <= r_addr + ADDR_ONE;
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                    r_cnt  <= r_cnt;
                end
            endcase
        end
    end

    // Read output slot: capture has priority over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
        end else if (r_state == RD_CAPT) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= mem_dout;
            r_rd_last  <= w_cnt_zero;
        end else if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
        end
    end

    assign req_ready = w_req_ready & rst_n;
    assign wr_ready  = w_wr_ready & rst_n;
    assign mem_en    = w_mem_en & rst_n;
    assign mem_we    = w_mem_we & rst_n;
    assign mem_addr  = r_addr;
    assign mem_din   = w_mem_we ? wr_data : '0;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_last   = r_rd_last;
    assign busy      = (r_state != IDLE);
    assign done      = w_done;

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master: expected MEM accesses and read beats are queued
// by the stimulus from a flat reference memory, and a monitor compares them as they appear.
module tb_mem_burst_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [4:0] req_addr, req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready, rd_last;
    logic [7:0] rd_data;
    logic       busy, done;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    logic [7:0]  tb_mem  [0:31];
    logic [7:0]  ref_mem [0:31];
    logic [12:0] wq[$];
    logic [8:0]  rq[$];
    logic [4:0]  raq[$];
    int          latq[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, exp_done = 0, rd_issue_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Synchronous single-port MEM model
    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
        mem_dout <= 8'h00;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) tb_mem[mem_addr] = mem_din;
            if (mem_en && !mem_we) mem_dout <= tb_mem[mem_addr];
        end
    end

    // Monitor: compares every MEM access and read beat against the queued expectations
    initial begin : monitor
        logic       pv, pr, pl;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (mem_en && mem_we) begin
                    if (wq.size() == 0) fail_now("unexpected_write");
                    else chk("write_addr_data", {19'd0, mem_addr, mem_din}, {19'd0, wq.pop_front()});
                end
                if (mem_en && !mem_we) begin
                    rd_issue_cnt++;
                    chk("read_din_zero", {24'd0, mem_din}, 32'd0);
                    chk("issue_slot_free", {31'd0, (!rd_valid || rd_ready)}, 32'd1);
                    if (raq.size() == 0) fail_now("unexpected_read");
                    else chk("read_addr", {27'd0, mem_addr}, {27'd0, raq.pop_front()});
                    latq.push_back(cyc + 2);
                end
                if (pv && !pr)
                    chk("rd_hold", {22'd0, rd_valid, rd_last, rd_data}, {22'd0, 1'b1, pl, pd});
                if (rd_valid && (!pv || pr)) begin
                    if (latq.size() == 0) fail_now("unexpected_rd_valid");
                    else chk("rd_latency", cyc, latq.pop_front());
                end
                if (rd_valid && rd_ready) begin
                    if (rq.size() == 0) fail_now("unexpected_rd_beat");
                    else chk("rd_beat_last_data", {23'd0, rd_last, rd_data}, {23'd0, rq.pop_front()});
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
                end
                pv = rd_valid; pr = rd_ready; pl = rd_last; pd = rd_data;
            end
        end
    end

    task automatic start_req(input logic w, input logic [4:0] a, input logic [4:0] len);
        int t = 0;
        while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!req_ready) fail_now("req_ready_timeout");
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("req_ready_low_when_busy", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin @(posedge clk); #1; t++; end
        if (busy) fail_now("idle_timeout");
        exp_done++;
        chk("done_count", done_cnt, exp_done);
        chk("req_ready_in_idle", {31'd0, req_ready}, 32'd1);
        chk("write_queue_drained", wq.size(), 32'd0);
        chk("read_queue_drained", rq.size(), 32'd0);
    endtask

    // dmode: 0 random data, 1 AA/BB/CC.., 2 data equals address; vmode: 0 steady, 1 random, 2 3-cycle gap
    task automatic do_write(input logic [4:0] a, input logic [4:0] len, input int dmode, input int vmode);
        logic [7:0] d[$];
        logic [4:0] ad;
        logic       v, take;
        int         i = 0, t = 0;
        for (int k = 0; k <= int'(len); k++) begin
            ad = 5'((int'(a) + k) % 32);
            case (dmode)
                0:       d.push_back(8'($urandom_range(0, 255)));
                1:       d.push_back(8'(8'hAA + 17 * k));
                default: d.push_back(8'(ad));
            endcase
            ref_mem[ad] = d[k];
            wq.push_back({ad, d[k]});
        end
        start_req(1'b1, a, len);
        while (i <= int'(len) && t < 200) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (t >= 3);
            endcase
            wr_valid = v;
            wr_data  = v ? d[i] : 8'h5A;
            #1;
            if (vmode == 2 && !v) chk("no_access_in_gap", {31'd0, mem_en}, 32'd0);
            take = v && wr_ready;
            @(posedge clk); #1;
            if (take) i++;
            t++;
        end
        wr_valid = 1'b0;
        if (i <= int'(len)) fail_now("write_beat_timeout");
        if (vmode == 0) chk("write_cycles", t, int'(len) + 1);
        wait_idle();
    endtask

    task automatic push_read(input logic [4:0] a, input logic [4:0] len);
        logic [4:0] ad;
        for (int k = 0; k <= int'(len); k++) begin
            ad = 5'((int'(a) + k) % 32);
            raq.push_back(ad);
            rq.push_back({(k == int'(len)), ref_mem[ad]});
        end
    endtask

    // bmode: 0 always ready, 1 random ready, 2 first beat held off for 5 cycles
    task automatic do_read(input logic [4:0] a, input logic [4:0] len, input int bmode);
        int t = 0, held = 0;
        push_read(a, len);
        start_req(1'b0, a, len);
        while (rq.size() != 0 && t < 2000) begin
            case (bmode)
                0: rd_ready = 1'b1;
                1: rd_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rd_valid && held < 5) begin rd_ready = 1'b0; held++; end
                    else rd_ready = 1'b1;
                end
            endcase
            @(posedge clk); #1;
            t++;
        end
        rd_ready = 1'b1;
        if (rq.size() != 0) fail_now("read_beat_timeout");
        wait_idle();
    endtask

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int base, t;
        logic [4:0] a, len;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_len = 5'd0;
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data_last", {23'd0, rd_last, rd_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        do_write(5'd30, 5'd3, 1, 0);
        do_read(5'd30, 5'd3, 0);
        do_read(5'd30, 5'd1, 2);
        do_write(5'd7, 5'd0, 0, 2);
        do_write(5'd31, 5'd31, 2, 0);
        do_read(5'd0, 5'd31, 0);
        for (int k = 0; k < 16; k++) begin
            a   = 5'($urandom_range(0, 31));
            len = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_write(a, len, 0, int'($urandom_range(0, 1)));
            else do_read(a, len, int'($urandom_range(0, 1)));
        end

        // Reset during the third beat of a read burst
        base = rd_issue_cnt;
        push_read(5'd10, 5'd5);
        rd_ready = 1'b1;
        start_req(1'b0, 5'd10, 5'd5);
        t = 0;
        while (rd_issue_cnt - base < 3 && t < 100) begin @(posedge clk); #1; t++; end
        if (rd_issue_cnt - base < 3) fail_now("abort_issue_timeout");
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        wq.delete(); rq.delete(); raq.delete(); latq.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, exp_done);
        rst_n = 1'b1;
        #1;
        chk("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
        do_write(5'd3, 5'd2, 0, 0);
        do_read(5'd3, 5'd2, 1);
        do_read(5'd12, 5'd4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
